// File: rtl/clk_div_multi_if.sv
// Interface bundling the per-channel enable/ratio inputs and divided-clock outputs of clk_div_multi.
// The o_tick member exists only when CLK_DIV_TICK_EN is defined.
interface clk_div_multi_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0]       i_clk_en;
  logic [CHANNELS*WIDTH-1:0] i_div_ratio;
  logic [CHANNELS-1:0]       o_div_clk;
  logic [CHANNELS-1:0]       o_locked;
`ifdef CLK_DIV_TICK_EN
  logic [CHANNELS-1:0]       o_tick;
`endif

`ifdef CLK_DIV_TICK_EN
  modport master (
    output i_clk_en, i_div_ratio,
    input  o_div_clk, o_locked, o_tick
  );
  modport slave (
    input  i_clk_en, i_div_ratio,
    output o_div_clk, o_locked, o_tick
  );
`else
  modport master (
    output i_clk_en, i_div_ratio,
    input  o_div_clk, o_locked
  );
  modport slave (
    input  i_clk_en, i_div_ratio,
    output o_div_clk, o_locked
  );
`endif
endinterface

// File: rtl/clk_div_multi.sv
// N-channel integer clock divider with glitch-free ratio reload at period boundaries.
// Optional macro CLK_DIV_TICK_EN adds a per-channel o_tick pulse aligned with each divided-clock rise.
module clk_div_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
) (
  input  logic          i_ref_clk,
  input  logic          i_rst_n,
  clk_div_multi_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  state_e           state_q   [CHANNELS];
  state_e           state_d   [CHANNELS];
  logic [WIDTH-1:0] cnt_q     [CHANNELS];
  logic [WIDTH-1:0] cnt_d     [CHANNELS];
  logic [WIDTH-1:0] r_act_q   [CHANNELS];
  logic [WIDTH-1:0] r_act_d   [CHANNELS];
  logic [WIDTH-1:0] ratio     [CHANNELS];
  logic [WIDTH-1:0] half      [CHANNELS];
  logic [WIDTH-1:0] cnt_inc   [CHANNELS];
  logic [CHANNELS-1:0] div_clk_q;
  logic [CHANNELS-1:0] div_clk_d;
  logic [CHANNELS-1:0] tick_q;
  logic [CHANNELS-1:0] tick_d;
  logic [CHANNELS-1:0] div_clk_o;
  logic [CHANNELS-1:0] locked_o;

  // Next-state logic for every channel; a channel only ever loads a new ratio when it
  // starts a fresh period, so the output never sees a truncated high or low phase.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      state_d[k]   = state_q[k];
      cnt_d[k]     = cnt_q[k];
      r_act_d[k]   = r_act_q[k];
      div_clk_d[k] = div_clk_q[k];
      tick_d[k]    = 1'b0;
      ratio[k]     = bus.i_div_ratio[k*WIDTH +: WIDTH];
      half[k]      = r_act_q[k] - (r_act_q[k] >> 1);
      cnt_inc[k]   = cnt_q[k] + ONE;

      unique case (state_q[k])
        IDLE: begin
          cnt_d[k]     = '0;
          div_clk_d[k] = 1'b0;
          if (bus.i_clk_en[k] && (ratio[k] >= TWO)) begin
            r_act_d[k]   = ratio[k];
            div_clk_d[k] = 1'b1;
            tick_d[k]    = 1'b1;
            state_d[k]   = RUN;
          end
        end
        RUN: begin
          if (!bus.i_clk_en[k]) begin
            // Disable aborts the current period immediately.
            state_d[k]   = IDLE;
            cnt_d[k]     = '0;
            div_clk_d[k] = 1'b0;
          end else if (cnt_q[k] != (r_act_q[k] - ONE)) begin
            cnt_d[k]     = cnt_inc[k];
            div_clk_d[k] = (cnt_inc[k] < half[k]);
          end else if (ratio[k] >= TWO) begin
            r_act_d[k]   = ratio[k];
            cnt_d[k]     = '0;
            div_clk_d[k] = 1'b1;
            tick_d[k]    = 1'b1;
          end else begin
            state_d[k]   = IDLE;
            cnt_d[k]     = '0;
            div_clk_d[k] = 1'b0;
          end
        end
        default: begin
          state_d[k]   = IDLE;
          cnt_d[k]     = '0;
          div_clk_d[k] = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= IDLE;
        cnt_q[k]   <= '0;
        r_act_q[k] <= '0;
      end
      div_clk_q <= '0;
      tick_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
        r_act_q[k] <= r_act_d[k];
      end
      div_clk_q <= div_clk_d;
      tick_q    <= tick_d;
    end
  end

  // Bypass mux: an idle channel passes the reference clock straight through.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      div_clk_o[k] = (state_q[k] == IDLE) ? i_ref_clk : div_clk_q[k];
      locked_o[k]  = (state_q[k] == RUN);
    end
  end

  assign bus.o_div_clk = div_clk_o;
  assign bus.o_locked  = locked_o;

`ifdef CLK_DIV_TICK_EN
  assign bus.o_tick = tick_q;
`else
  logic unused_tick;
  assign unused_tick = ^tick_q;
`endif

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: ratio table, mid-period ratio change, abort, bypass and async reset.
module tb_clk_div_multi;
  localparam int WIDTH    = 8;
  localparam int CHANNELS = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  clk_div_multi_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

  clk_div_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .i_ref_clk (clk),
    .i_rst_n   (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] ratio;
    int               nsamp;
    logic [31:0]      exp_wave;
    logic [31:0]      exp_tick;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.i_clk_en    = '0;
    bus.i_div_ratio = '0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] acc0, acc1, tck0, tck1;

    // First sample (MSB) is taken right after the edge that enters RUN.
    vecs[0] = '{ratio: 8'd4, nsamp: 8,  exp_wave: 32'b11001100,   exp_tick: 32'b10001000};
    vecs[1] = '{ratio: 8'd5, nsamp: 10, exp_wave: 32'b1110011100, exp_tick: 32'b1000010000};
    vecs[2] = '{ratio: 8'd3, nsamp: 6,  exp_wave: 32'b110110,     exp_tick: 32'b100100};
    vecs[3] = '{ratio: 8'd2, nsamp: 4,  exp_wave: 32'b1010,       exp_tick: 32'b1010};

    bus.i_clk_en    = '0;
    bus.i_div_ratio = '0;

    for (int v = 0; v < 4; v++) begin
      rst_n           = 1'b0;
      bus.i_clk_en    = '0;
      bus.i_div_ratio = '0;
      step();
      check("rst_locked", 32'(bus.o_locked), 32'd0);
      check("rst_bypass_hi", 32'(bus.o_div_clk[0]), 32'd1);
      @(negedge clk);
      #1;
      check("rst_bypass_lo", 32'(bus.o_div_clk[0]), 32'd0);
`ifdef CLK_DIV_TICK_EN
      check("rst_tick", 32'(bus.o_tick), 32'd0);
`endif
      step();
      rst_n = 1'b1;
      bus.i_div_ratio[WIDTH-1:0] = vecs[v].ratio;
      bus.i_clk_en = 2'b01;
      step();
      check("run_locked", 32'(bus.o_locked), 32'd1);
      acc0 = '0;
      tck0 = '0;
      for (int i = 0; i < vecs[v].nsamp; i++) begin
        acc0 = (acc0 << 1) | 32'(bus.o_div_clk[0]);
`ifdef CLK_DIV_TICK_EN
        tck0 = (tck0 << 1) | 32'(bus.o_tick[0]);
`endif
        step();
      end
      check($sformatf("wave_r%0d", vecs[v].ratio), acc0, vecs[v].exp_wave);
`ifdef CLK_DIV_TICK_EN
      check($sformatf("tick_r%0d", vecs[v].ratio), tck0, vecs[v].exp_tick);
`endif
    end

    // Ratio change mid-period: 6-cycle period completes, then periods of 3.
    do_reset();
    bus.i_div_ratio[WIDTH-1:0] = 8'd6;
    bus.i_clk_en = 2'b01;
    step();
    acc0 = '0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) bus.i_div_ratio[WIDTH-1:0] = 8'd3;
      acc0 = (acc0 << 1) | 32'(bus.o_div_clk[0]);
      step();
    end
    check("ratio_change", acc0, 32'b111000110110);

    // Disable mid-high phase, then re-enable for a fresh period.
    do_reset();
    bus.i_div_ratio[WIDTH-1:0] = 8'd4;
    bus.i_clk_en = 2'b01;
    step();
    step();
    check("abort_pre_high", 32'(bus.o_div_clk[0]), 32'd1);
    bus.i_clk_en = 2'b00;
    step();
    check("abort_locked", 32'(bus.o_locked[0]), 32'd0);
    check("abort_bypass_hi", 32'(bus.o_div_clk[0]), 32'd1);
    @(negedge clk);
    #1;
    check("abort_bypass_lo", 32'(bus.o_div_clk[0]), 32'd0);
    bus.i_clk_en = 2'b01;
    step();
    check("reen_locked", 32'(bus.o_locked[0]), 32'd1);
    acc0 = '0;
    for (int i = 0; i < 4; i++) begin
      acc0 = (acc0 << 1) | 32'(bus.o_div_clk[0]);
      step();
    end
    check("reen_wave", acc0, 32'b1100);

    // Ratios 1 and 0 keep the channel in bypass; dropping to 1 takes effect at the boundary.
    do_reset();
    bus.i_div_ratio[WIDTH-1:0] = 8'd1;
    bus.i_clk_en = 2'b01;
    step();
    step();
    check("r1_locked", 32'(bus.o_locked[0]), 32'd0);
    check("r1_bypass", 32'(bus.o_div_clk[0]), 32'(clk));
    bus.i_div_ratio[WIDTH-1:0] = 8'd0;
    step();
    check("r0_locked", 32'(bus.o_locked[0]), 32'd0);
    bus.i_div_ratio[WIDTH-1:0] = 8'd4;
    step();
    step();
    bus.i_div_ratio[WIDTH-1:0] = 8'd1;
    step();
    check("drop_cnt2_locked", 32'(bus.o_locked[0]), 32'd1);
    check("drop_cnt2_low", 32'(bus.o_div_clk[0]), 32'd0);
    step();
    check("drop_cnt3_locked", 32'(bus.o_locked[0]), 32'd1);
    step();
    check("drop_idle_locked", 32'(bus.o_locked[0]), 32'd0);

    // Two independent channels, then async reset mid-run.
    do_reset();
    bus.i_div_ratio = {8'd8, 8'd3};
    bus.i_clk_en    = 2'b11;
    step();
    acc0 = '0; acc1 = '0; tck0 = '0; tck1 = '0;
    for (int i = 0; i < 8; i++) begin
      acc0 = (acc0 << 1) | 32'(bus.o_div_clk[0]);
      acc1 = (acc1 << 1) | 32'(bus.o_div_clk[1]);
`ifdef CLK_DIV_TICK_EN
      tck0 = (tck0 << 1) | 32'(bus.o_tick[0]);
      tck1 = (tck1 << 1) | 32'(bus.o_tick[1]);
`endif
      step();
    end
    check("dual_ch0_wave", acc0, 32'b11011011);
    check("dual_ch1_wave", acc1, 32'b11110000);
`ifdef CLK_DIV_TICK_EN
    check("dual_ch0_tick", tck0, 32'b10010010);
    check("dual_ch1_tick", tck1, 32'b10000000);
`endif
    check("dual_locked", 32'(bus.o_locked), 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_locked", 32'(bus.o_locked), 32'd0);
    check("async_rst_bypass", 32'(bus.o_div_clk), {30'd0, clk, clk});
`ifdef CLK_DIV_TICK_EN
    check("async_rst_tick", 32'(bus.o_tick), 32'd0);
`endif
    step();
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
